// File: rtl/cpu_pkg.sv
// Shared CPU types: ALU function codes and the issue-stage state encoding.
// The function code is two bits wide so that undefined codes can still reach the ALU.
package cpu_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_MUL = 2'd1
  } aluFunc_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } issue_state_t;

endpackage

// File: rtl/alu_issue_wb_regfile.sv
// regfile: NREGS x DW storage with two operand read ports, one debug read port and one write port.
// Latency: reads are combinational; a write lands on the next rising clk edge.
// Backpressure: none; a write is accepted every cycle that we is high.
module regfile
  import cpu_pkg::*;
#(
  parameter int DW      = 8,
  parameter int NREGS   = 8,
  parameter int R0_ZERO = 1,
  parameter int AW      = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] ra_addr,
  output logic [DW-1:0] ra_data,
  input  logic [AW-1:0] rb_addr,
  output logic [DW-1:0] rb_data,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata
);

  logic [DW-1:0] mem [NREGS];
  logic          r0_hard;

  assign r0_hard = (R0_ZERO != 0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we && !(r0_hard && (waddr == '0))) begin
      mem[waddr] <= wdata;
    end
  end

  // r0 is forced to zero on every read port, so no write ever needs to be undone.
  assign ra_data  = (r0_hard && (ra_addr  == '0)) ? '0 : mem[ra_addr];
  assign rb_data  = (r0_hard && (rb_addr  == '0)) ? '0 : mem[rb_addr];
  assign dbg_data = (r0_hard && (dbg_addr == '0)) ? '0 : mem[dbg_addr];

endmodule

// File: rtl/alu_issue_wb.sv
// alu_issue_wb: issues one decoded instruction to the ALU and writes the result back to rd.
// Latency: accept at E0, result captured at E1, register written at E2; one instruction per 3 cycles.
// Backpressure: instr_ready is high only in IDLE; instr_valid outside IDLE is ignored.
module alu_issue_wb
  import cpu_pkg::*;
#(
  parameter int DW      = 8,
  parameter int NREGS   = 8,
  parameter int R0_ZERO = 1,
  parameter int AW      = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  aluFunc_t      instr_func,
  input  logic [AW-1:0] instr_rd,
  input  logic [AW-1:0] instr_rs,
  input  logic [AW-1:0] instr_rt,
  input  logic [DW-1:0] instr_imm,
  input  logic          instr_use_imm,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output aluFunc_t      alu_func,
  input  logic [DW-1:0] alu_result,
  output logic          wb_valid,
  output logic [AW-1:0] wb_addr,
  output logic [DW-1:0] wb_data,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  issue_state_t  state, state_nxt;
  logic [AW-1:0] rd_q;
  logic [DW-1:0] rs_data, rt_data;
  logic          accept;

  regfile #(
    .DW(DW), .NREGS(NREGS), .R0_ZERO(R0_ZERO), .AW(AW)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .ra_addr  (instr_rs),
    .ra_data  (rs_data),
    .rb_addr  (instr_rt),
    .rb_data  (rt_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .we       (wb_valid),
    .waddr    (wb_addr),
    .wdata    (wb_data)
  );

  assign accept = instr_valid && (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_nxt = EXEC;
      end
      EXEC:    state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are sampled at accept, so an rs/rt equal to rd sees the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_func <= ALU_ADD;
      rd_q     <= '0;
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
    end else begin
      if (accept) begin
        alu_a    <= rs_data;
        alu_b    <= instr_use_imm ? instr_imm : rt_data;
        alu_func <= instr_func;
        rd_q     <= instr_rd;
      end
      wb_valid <= (state == EXEC);
      if (state == EXEC) begin
        wb_data <= alu_result;
        wb_addr <= rd_q;
      end
    end
  end

endmodule
